psu_redundancy_mgr: RTL and testbench

// - Parametrised PSU manager for 1..16 supplies: per-PSU debounce, 7-state per-PSU FSM, N+R redundancy status,

---
 rtl/psu_redundancy_mgr.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_psu_redundancy_mgr.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psu_redundancy_mgr.sv
// PSU redundancy manager: per-channel input debounce and state machine, N+R
// redundancy status, brownout supervision and a delayed ACOK link.
module psu_redundancy_mgr #(
    parameter int unsigned NUM_PSU          = 4,
    parameter int unsigned DEB_MS           = 3,
    parameter int unsigned DCOK_TMO_MS      = 500,
    parameter int unsigned BROWNOUT_WARN_MS = 5,
    parameter int unsigned REDUN_MIN        = 2,
    parameter int unsigned LINK_DLY_S       = 6
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         t1ms,
    input  logic                         t1s,
    input  logic                         power_supply_on,
    input  logic                         st_ps_on,
    input  logic                         enable_hold,
    input  logic [NUM_PSU-1:0]           xreg_ps_enable,
    input  logic                         fail_clr,
    input  logic                         bad_fuse_det,
    input  logic                         pgd_p12v_droop,
    input  logic [NUM_PSU-1:0]           ps_prsnt_n,
    input  logic [NUM_PSU-1:0]           ps_acok,
    input  logic [NUM_PSU-1:0]           ps_dcok,
    output logic [NUM_PSU-1:0]           ps_on_n,
    output logic [3*NUM_PSU-1:0]         ps_state,
    output logic [NUM_PSU-1:0]           ps_fail,
    output logic [$clog2(NUM_PSU+1)-1:0] good_count,
    output logic                         redundancy_ok,
    output logic                         ps_caution,
    output logic                         ps_critical,
    output logic                         brownout_warning,
    output logic                         brownout_fault,
    output logic                         ps_acok_link
);

    localparam int unsigned NF     = 3 * NUM_PSU;
    localparam int unsigned CNT_W  = $clog2(NUM_PSU + 1);
    localparam int unsigned TMO_W  = $clog2(DCOK_TMO_MS + 2);
    localparam int unsigned BO_W   = $clog2(BROWNOUT_WARN_MS + 2);
    localparam int unsigned DEB_W  = 4;
    localparam int unsigned LINK_W = 4;
    localparam logic [NF-1:0] FILT_RST = {{(2 * NUM_PSU){1'b0}}, {NUM_PSU{1'b1}}};

    typedef enum logic [2:0] {
        ST_ABSENT    = 3'd0,
        ST_UNPLUGGED = 3'd1,
        ST_STANDBY   = 3'd2,
        ST_ON_WAIT   = 3'd3,
        ST_ACTIVE    = 3'd4,
        ST_BROWNOUT  = 3'd5,
        ST_FAILED    = 3'd6
    } psu_state_e;

    logic [NF-1:0]      raw_c;
    logic [NF-1:0]      filt_q, filt_d;
    logic [DEB_W-1:0]   deb_q [NF];
    logic [DEB_W-1:0]   deb_d [NF];
    logic [NUM_PSU-1:0] prsnt_n_f, acok_f, dcok_f;
    logic [NUM_PSU-1:0] en_q, en_d;
    logic               clr_pend_q, clr_pend_d, clr_now_c;
    psu_state_e         state_q [NUM_PSU];
    psu_state_e         state_d [NUM_PSU];
    logic [TMO_W-1:0]   tmo_q [NUM_PSU];
    logic [TMO_W-1:0]   tmo_d [NUM_PSU];
    logic [NUM_PSU-1:0] ps_on_n_q, ps_on_n_d;
    logic [BO_W-1:0]    bo_cnt_q, bo_cnt_d;
    logic               warn_q, warn_d;
    logic               fault_q, fault_d;
    logic [LINK_W-1:0]  link_cnt_q, link_cnt_d;
    logic               any_bo_c;
    logic               link_raw_c;
    logic               all_ok_c;
    logic [NUM_PSU-1:0] absent_c;
    logic [CNT_W-1:0]   present_cnt_c;

    assign raw_c     = {ps_dcok, ps_acok, ps_prsnt_n};
    assign prsnt_n_f = filt_q[NUM_PSU-1:0];
    assign acok_f    = filt_q[2*NUM_PSU-1:NUM_PSU];
    assign dcok_f    = filt_q[NF-1:2*NUM_PSU];

    // Debounce: a filtered bit follows raw after DEB_MS consecutive differing ms samples.
    always_comb begin
        filt_d = filt_q;
        for (int k = 0; k < NF; k++) begin
            deb_d[k] = deb_q[k];
            if (t1ms) begin
                if (raw_c[k] == filt_q[k]) begin
                    deb_d[k] = '0;
                end else if (deb_q[k] == DEB_W'(DEB_MS - 1)) begin
                    filt_d[k] = raw_c[k];
                    deb_d[k]  = '0;
                end else begin
                    deb_d[k] = deb_q[k] + DEB_W'(1);
                end
            end
        end
    end

    assign en_d       = (t1ms && !enable_hold) ? xreg_ps_enable : en_q;
    // fail_clr is a single-clock pulse; hold it until the next ms tick consumes it.
    assign clr_now_c  = clr_pend_q | fail_clr;
    assign clr_pend_d = t1ms ? 1'b0 : clr_now_c;

    // Per-channel next state, evaluated only on ms ticks.
    always_comb begin
        for (int i = 0; i < NUM_PSU; i++) begin
            state_d[i] = state_q[i];
            tmo_d[i]   = tmo_q[i];
            if (t1ms) begin
                if (prsnt_n_f[i]) begin
                    state_d[i] = ST_ABSENT;
                end else begin
                    case (state_q[i])
                        ST_ABSENT: begin
                            state_d[i] = acok_f[i] ? ST_STANDBY : ST_UNPLUGGED;
                        end
                        ST_UNPLUGGED: begin
                            if (acok_f[i]) state_d[i] = ST_STANDBY;
                        end
                        ST_STANDBY: begin
                            if (!acok_f[i]) begin
                                state_d[i] = ST_UNPLUGGED;
                            end else if (power_supply_on && en_q[i]) begin
                                state_d[i] = ST_ON_WAIT;
                                tmo_d[i]   = '0;
                            end
                        end
                        ST_ON_WAIT: begin
                            if (dcok_f[i] && acok_f[i]) begin
                                state_d[i] = ST_ACTIVE;
                            end else if (!acok_f[i]) begin
                                state_d[i] = ST_UNPLUGGED;
                            end else if (!power_supply_on || !en_q[i]) begin
                                state_d[i] = ST_STANDBY;
                            end else if (tmo_q[i] == TMO_W'(DCOK_TMO_MS)) begin
                                state_d[i] = ST_FAILED;
                            end else begin
                                tmo_d[i] = tmo_q[i] + TMO_W'(1);
                            end
                        end
                        ST_ACTIVE: begin
                            if (!acok_f[i]) begin
                                state_d[i] = ST_BROWNOUT;
                            end else if (!dcok_f[i] && !bad_fuse_det) begin
                                state_d[i] = ST_FAILED;
                            end else if (!power_supply_on || !en_q[i]) begin
                                state_d[i] = ST_STANDBY;
                            end
                        end
                        ST_BROWNOUT: begin
                            if (acok_f[i] && dcok_f[i]) begin
                                state_d[i] = ST_ACTIVE;
                            end else if (acok_f[i]) begin
                                state_d[i] = ST_ON_WAIT;
                                tmo_d[i]   = '0;
                            end else if (!power_supply_on && !fault_q) begin
                                state_d[i] = ST_UNPLUGGED;
                            end
                        end
                        ST_FAILED: begin
                            if (st_ps_on || clr_now_c) state_d[i] = ST_STANDBY;
                        end
                        default: state_d[i] = ST_ABSENT;
                    endcase
                end
            end
        end
    end

    // Brownout persistence counter, warning and sticky fault.
    always_comb begin
        any_bo_c = 1'b0;
        for (int i = 0; i < NUM_PSU; i++) begin
            if (state_q[i] == ST_BROWNOUT) any_bo_c = 1'b1;
        end
        bo_cnt_d = bo_cnt_q;
        fault_d  = fault_q;
        if (st_ps_on) begin
            bo_cnt_d = '0;
            fault_d  = 1'b0;
        end else begin
            if (t1ms) begin
                if (!any_bo_c) begin
                    bo_cnt_d = '0;
                end else if (bo_cnt_q != BO_W'(BROWNOUT_WARN_MS)) begin
                    bo_cnt_d = bo_cnt_q + BO_W'(1);
                end
            end
            if (warn_q && !pgd_p12v_droop) fault_d = 1'b1;
        end
        warn_d = (bo_cnt_d == BO_W'(BROWNOUT_WARN_MS));
    end

    // Supply enables follow the next state so they change together with ps_state.
    always_comb begin
        ps_on_n_d = '1;
        for (int i = 0; i < NUM_PSU; i++) begin
            if (state_d[i] == ST_ON_WAIT || state_d[i] == ST_ACTIVE ||
                state_d[i] == ST_BROWNOUT || (state_d[i] != ST_ABSENT && fault_d)) begin
                ps_on_n_d[i] = 1'b0;
            end
        end
    end

    // Status derived from the registered channel states.
    always_comb begin
        ps_state      = '0;
        ps_fail       = '0;
        absent_c      = '0;
        good_count    = '0;
        present_cnt_c = '0;
        all_ok_c      = 1'b1;
        for (int i = 0; i < NUM_PSU; i++) begin
            ps_state[3*i +: 3] = state_q[i];
            ps_fail[i]         = (state_q[i] == ST_FAILED);
            absent_c[i]        = (state_q[i] == ST_ABSENT);
            if (state_q[i] == ST_ACTIVE) good_count = good_count + CNT_W'(1);
            if (state_q[i] != ST_ABSENT) begin
                present_cnt_c = present_cnt_c + CNT_W'(1);
                if (state_q[i] != ST_ACTIVE) all_ok_c = 1'b0;
            end
        end
    end

    assign link_raw_c = (32'(present_cnt_c) >= 32'd2) && all_ok_c;

    always_comb begin
        link_cnt_d = link_cnt_q;
        if (!link_raw_c) begin
            link_cnt_d = '0;
        end else if (t1s && link_cnt_q != LINK_W'(LINK_DLY_S)) begin
            link_cnt_d = link_cnt_q + LINK_W'(1);
        end
    end

    assign redundancy_ok    = (32'(good_count) >= REDUN_MIN);
    assign ps_caution       = |ps_fail;
    assign ps_critical      = &(ps_fail | absent_c);
    assign ps_on_n          = ps_on_n_q;
    assign brownout_warning = warn_q;
    assign brownout_fault   = fault_q;
    // Link falls in the same clock the raw condition drops; only the rise is delayed.
    assign ps_acok_link     = (NUM_PSU > 1) && link_raw_c &&
                              (link_cnt_q == LINK_W'(LINK_DLY_S));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q     <= FILT_RST;
            en_q       <= '0;
            clr_pend_q <= 1'b0;
            ps_on_n_q  <= '1;
            bo_cnt_q   <= '0;
            warn_q     <= 1'b0;
            fault_q    <= 1'b0;
            link_cnt_q <= '0;
            for (int k = 0; k < NF; k++) begin
                deb_q[k] <= '0;
            end
            for (int i = 0; i < NUM_PSU; i++) begin
                state_q[i] <= ST_ABSENT;
                tmo_q[i]   <= '0;
            end
        end else begin
            filt_q     <= filt_d;
            en_q       <= en_d;
            clr_pend_q <= clr_pend_d;
            ps_on_n_q  <= ps_on_n_d;
            bo_cnt_q   <= bo_cnt_d;
            warn_q     <= warn_d;
            fault_q    <= fault_d;
            link_cnt_q <= link_cnt_d;
            for (int k = 0; k < NF; k++) begin
                deb_q[k] <= deb_d[k];
            end
            for (int i = 0; i < NUM_PSU; i++) begin
                state_q[i] <= state_d[i];
                tmo_q[i]   <= tmo_d[i];
            end
        end
    end

endmodule

// File: tb/tb_psu_redundancy_mgr.sv
// Directed bench for psu_redundancy_mgr: a vector table for bring-up and DCOK
// loss/clear, then hand-written brownout, timeout, glitch and reset sequences.
module tb_psu_redundancy_mgr;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        t1ms = 1'b0;
    logic        t1s = 1'b0;
    logic        power_supply_on = 1'b0;
    logic        st_ps_on = 1'b0;
    logic        enable_hold = 1'b0;
    logic [3:0]  xreg_ps_enable = 4'h0;
    logic        fail_clr = 1'b0;
    logic        bad_fuse_det = 1'b0;
    logic        pgd_p12v_droop = 1'b1;
    logic [3:0]  ps_prsnt_n = 4'hF;
    logic [3:0]  ps_acok = 4'h0;
    logic [3:0]  ps_dcok = 4'h0;
    logic [3:0]  ps_on_n;
    logic [11:0] ps_state;
    logic [3:0]  ps_fail;
    logic [2:0]  good_count;
    logic        redundancy_ok, ps_caution, ps_critical;
    logic        brownout_warning, brownout_fault, ps_acok_link;

    int n_pass = 0;
    int n_total = 0;

    psu_redundancy_mgr dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .t1ms             (t1ms),
        .t1s              (t1s),
        .power_supply_on  (power_supply_on),
        .st_ps_on         (st_ps_on),
        .enable_hold      (enable_hold),
        .xreg_ps_enable   (xreg_ps_enable),
        .fail_clr         (fail_clr),
        .bad_fuse_det     (bad_fuse_det),
        .pgd_p12v_droop   (pgd_p12v_droop),
        .ps_prsnt_n       (ps_prsnt_n),
        .ps_acok          (ps_acok),
        .ps_dcok          (ps_dcok),
        .ps_on_n          (ps_on_n),
        .ps_state         (ps_state),
        .ps_fail          (ps_fail),
        .good_count       (good_count),
        .redundancy_ok    (redundancy_ok),
        .ps_caution       (ps_caution),
        .ps_critical      (ps_critical),
        .brownout_warning (brownout_warning),
        .brownout_fault   (brownout_fault),
        .ps_acok_link     (ps_acok_link)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n_ms;
        int         n_s;
        bit         clr;
        logic [3:0] prsnt_n;
        logic [3:0] acok;
        logic [3:0] dcok;
        bit         pso;
        bit         fuse;
        logic [11:0] e_state;
        logic [3:0] e_on_n;
        logic [2:0] e_good;
        bit         e_red;
        bit         e_link;
        logic [3:0] e_fail;
    } vec_t;

    vec_t vt [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Each tick is a one-clock pulse; the task returns on the negedge after it.
    task automatic ms(input int n);
        repeat (n) begin
            @(negedge clk); t1ms = 1'b1;
            @(negedge clk); t1ms = 1'b0;
        end
    endtask

    task automatic sec(input int n);
        repeat (n) begin
            @(negedge clk); t1s = 1'b1;
            @(negedge clk); t1s = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); fail_clr = 1'b1;
        @(negedge clk); fail_clr = 1'b0;
    endtask

    initial begin
        // n_ms n_s clr prsnt acok dcok pso fuse | state on_n good red link fail
        vt[0]  = '{3, 0, 0, 4'h0, 4'hF, 4'h0, 0, 0, 12'h000, 4'hF, 3'd0, 0, 0, 4'h0};
        vt[1]  = '{1, 0, 0, 4'h0, 4'hF, 4'h0, 0, 0, 12'h492, 4'hF, 3'd0, 0, 0, 4'h0};
        vt[2]  = '{1, 0, 0, 4'h0, 4'hF, 4'h0, 1, 0, 12'h6DB, 4'h0, 3'd0, 0, 0, 4'h0};
        vt[3]  = '{9, 0, 0, 4'h0, 4'hF, 4'h0, 1, 0, 12'h6DB, 4'h0, 3'd0, 0, 0, 4'h0};
        vt[4]  = '{3, 0, 0, 4'h0, 4'hF, 4'hF, 1, 0, 12'h6DB, 4'h0, 3'd0, 0, 0, 4'h0};
        vt[5]  = '{1, 0, 0, 4'h0, 4'hF, 4'hF, 1, 0, 12'h924, 4'h0, 3'd4, 1, 0, 4'h0};
        vt[6]  = '{0, 5, 0, 4'h0, 4'hF, 4'hF, 1, 0, 12'h924, 4'h0, 3'd4, 1, 0, 4'h0};
        vt[7]  = '{0, 1, 0, 4'h0, 4'hF, 4'hF, 1, 0, 12'h924, 4'h0, 3'd4, 1, 1, 4'h0};
        vt[8]  = '{4, 0, 0, 4'h0, 4'hF, 4'hE, 1, 1, 12'h924, 4'h0, 3'd4, 1, 1, 4'h0};
        vt[9]  = '{3, 0, 0, 4'h0, 4'hF, 4'hF, 1, 1, 12'h924, 4'h0, 3'd4, 1, 1, 4'h0};
        vt[10] = '{1, 0, 0, 4'h0, 4'hF, 4'hF, 1, 0, 12'h924, 4'h0, 3'd4, 1, 1, 4'h0};
        vt[11] = '{3, 0, 0, 4'h0, 4'hF, 4'hE, 1, 0, 12'h924, 4'h0, 3'd4, 1, 1, 4'h0};
        vt[12] = '{1, 0, 0, 4'h0, 4'hF, 4'hE, 1, 0, 12'h926, 4'h1, 3'd3, 1, 0, 4'h1};
        vt[13] = '{3, 0, 0, 4'h0, 4'hF, 4'hF, 1, 0, 12'h926, 4'h1, 3'd3, 1, 0, 4'h1};
        vt[14] = '{1, 0, 1, 4'h0, 4'hF, 4'hF, 1, 0, 12'h922, 4'h1, 3'd3, 1, 0, 4'h0};
        vt[15] = '{1, 0, 0, 4'h0, 4'hF, 4'hF, 1, 0, 12'h923, 4'h0, 3'd3, 1, 0, 4'h0};
        vt[16] = '{1, 0, 0, 4'h0, 4'hF, 4'hF, 1, 0, 12'h924, 4'h0, 3'd4, 1, 0, 4'h0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst ps_on_n", 32'(ps_on_n), 32'hF);
        check("rst ps_state", 32'(ps_state), 32'h0);
        check("rst good_count", 32'(good_count), 32'd0);
        check("rst redundancy_ok", 32'(redundancy_ok), 32'd0);
        check("rst ps_critical", 32'(ps_critical), 32'd1);
        check("rst warn/fault/link", 32'({brownout_warning, brownout_fault, ps_acok_link}), 32'd0);
        reset_n = 1'b1;
        xreg_ps_enable = 4'hF;

        // Bring-up, bad-fuse DCOK loss, real DCOK loss and fail_clr recovery
        for (int r = 0; r < 17; r++) begin
            ps_prsnt_n      = vt[r].prsnt_n;
            ps_acok         = vt[r].acok;
            ps_dcok         = vt[r].dcok;
            power_supply_on = vt[r].pso;
            bad_fuse_det    = vt[r].fuse;
            if (vt[r].clr) pulse_clr();
            ms(vt[r].n_ms);
            sec(vt[r].n_s);
            check($sformatf("row%0d ps_state", r), 32'(ps_state), 32'(vt[r].e_state));
            check($sformatf("row%0d ps_on_n", r), 32'(ps_on_n), 32'(vt[r].e_on_n));
            check($sformatf("row%0d good_count", r), 32'(good_count), 32'(vt[r].e_good));
            check($sformatf("row%0d redundancy_ok", r), 32'(redundancy_ok), 32'(vt[r].e_red));
            check($sformatf("row%0d ps_acok_link", r), 32'(ps_acok_link), 32'(vt[r].e_link));
            check($sformatf("row%0d ps_fail", r), 32'(ps_fail), 32'(vt[r].e_fail));
        end

        // Brownout on ch2 for 6 ms with 12V lost
        pgd_p12v_droop = 1'b0;
        ps_acok = 4'hB;
        ms(6);
        check("bo ch2 brownout", 32'(ps_state), 32'h964);
        check("bo ps_on_n", 32'(ps_on_n), 32'h0);
        check("bo warn early", 32'(brownout_warning), 32'd0);
        ps_acok = 4'hF;
        ms(2);
        check("bo warn at 4ms", 32'(brownout_warning), 32'd0);
        ms(1);
        check("bo warn at 5ms", 32'(brownout_warning), 32'd1);
        check("bo fault not yet", 32'(brownout_fault), 32'd0);
        @(negedge clk);
        check("bo fault set", 32'(brownout_fault), 32'd1);
        check("bo ps_on_n held", 32'(ps_on_n), 32'h0);
        ms(1);
        check("bo ch2 recovered", 32'(ps_state), 32'h924);
        ms(1);
        check("bo warn cleared", 32'(brownout_warning), 32'd0);
        check("bo fault sticky", 32'(brownout_fault), 32'd1);
        pgd_p12v_droop = 1'b1;
        @(negedge clk); st_ps_on = 1'b1;
        @(negedge clk); st_ps_on = 1'b0;
        check("bo fault cleared", 32'(brownout_fault), 32'd0);

        // ch1 DCOK never rises: timeout to FAILED, coincident clear loses
        power_supply_on = 1'b0;
        ms(1);
        check("tmo standby", 32'(ps_state), 32'h492);
        check("tmo ps_on_n off", 32'(ps_on_n), 32'hF);
        ps_dcok = 4'hD;
        ms(3);
        power_supply_on = 1'b1;
        ms(1);
        check("tmo on_wait", 32'(ps_state), 32'h6DB);
        ms(1);
        check("tmo ch1 waiting", 32'(ps_state), 32'h91C);
        ms(499);
        check("tmo ch1 at limit", 32'(ps_state), 32'h91C);
        @(negedge clk); t1ms = 1'b1; fail_clr = 1'b1;
        @(negedge clk); t1ms = 1'b0; fail_clr = 1'b0;
        check("tmo ch1 failed", 32'(ps_state), 32'h934);
        check("tmo ps_fail", 32'(ps_fail), 32'h2);
        check("tmo ps_caution", 32'(ps_caution), 32'd1);
        check("tmo ps_on_n", 32'(ps_on_n), 32'h2);
        ms(1);
        check("tmo failure wins", 32'(ps_state), 32'h934);
        pulse_clr();
        ms(1);
        check("clr standby", 32'(ps_state), 32'h914);
        check("clr ps_fail", 32'(ps_fail), 32'h0);
        ms(1);
        check("clr on_wait", 32'(ps_state), 32'h91C);
        check("clr ps_on_n", 32'(ps_on_n), 32'h0);
        ps_dcok = 4'hF;
        ms(4);
        check("clr ch1 active", 32'(ps_state), 32'h924);

        // ch3 removed together with DCOK loss, then ACOK glitches on ch0
        ps_prsnt_n = 4'h8;
        ps_dcok = 4'h7;
        ms(3);
        check("rm still active", 32'(ps_state), 32'h924);
        ms(1);
        check("rm ch3 absent", 32'(ps_state), 32'h124);
        check("rm ps_fail", 32'(ps_fail), 32'h0);
        check("rm ps_on_n", 32'(ps_on_n), 32'h8);
        check("rm ps_critical", 32'(ps_critical), 32'd0);
        repeat (3) begin
            @(negedge clk); ps_acok = 4'hE; t1ms = 1'b1;
            @(negedge clk); t1ms = 1'b0;
            @(negedge clk); ps_acok = 4'hF;
            ms(1);
        end
        ms(3);
        check("glitch no change", 32'(ps_state), 32'h124);

        // Asynchronous reset mid-ACTIVE, then re-qualification
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("arst ps_state", 32'(ps_state), 32'h0);
        check("arst ps_on_n", 32'(ps_on_n), 32'hF);
        check("arst good_count", 32'(good_count), 32'd0);
        check("arst link", 32'(ps_acok_link), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        ms(3);
        check("arst deb window", 32'(ps_state), 32'h0);
        ms(1);
        check("arst standby", 32'(ps_state), 32'h092);
        check("arst ps_on_n", 32'(ps_on_n), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
